// File: rtl/rtc_mode_arbiter.sv
// rtc_mode_arbiter: grants one of N_REQ write channels, or the read sequencer,
// onto the RTC protocol engine bus. Operator requests are latched only at the
// safe bus slot and only after the power-on init window has elapsed.
// Optional macro REQ_SYNC_EN: pass req_raw through a 2-flop synchronizer first.
module rtc_mode_arbiter #(
   parameter int              N_REQ       = 4,
   parameter int              AW          = 8,
   parameter int              DW          = 8,
   parameter int              CW          = 7,
   parameter logic [CW-1:0]   SAFE_SLOT   = 'h4A,
   parameter int              INIT_CYCLES = 1035,
   parameter int              PRIORITY    = 0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [CW-1:0]         slot_cnt,
   input  logic [N_REQ-1:0]      req_raw,
   input  logic [N_REQ*AW-1:0]   ch_addr,
   input  logic [N_REQ*DW-1:0]   ch_data,
   input  logic [AW-1:0]         rd_addr,
   output logic [N_REQ-1:0]      grant,
   output logic                  rd_grant,
   output logic                  init_active,
   output logic [AW-1:0]         bus_addr,
   output logic [DW-1:0]         bus_data,
   output logic                  bus_drive,
   output logic                  write_mode,
   output logic                  conflict,
   output logic                  mode_change
);

   localparam int             ICW       = $clog2(INIT_CYCLES + 1);
   localparam logic [ICW-1:0] INIT_LAST = ICW'(INIT_CYCLES - 1);

   logic [N_REQ-1:0] w_req_src;
   logic [ICW-1:0]   r_init_cnt;
   logic             r_init_active;
   logic [N_REQ-1:0] r_req_lat;
   logic [N_REQ-1:0] r_grant;
   logic             r_rd_grant;
   logic             r_conflict;
   logic             r_mode_change;
   logic             w_sample;
   logic             w_any;
   logic             w_multi;
   logic [N_REQ-1:0] w_lowest;
   logic [N_REQ-1:0] w_grant_nxt;
   logic             w_rd_nxt;
   logic             w_conflict_nxt;
   logic [AW-1:0]    w_addr_mux;
   logic [DW-1:0]    w_data_mux;

`ifdef REQ_SYNC_EN
   logic [N_REQ-1:0] r_sync1;
   logic [N_REQ-1:0] r_sync2;

   // Two-stage synchronizer for the asynchronous operator switches.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         // NOTE: non-blocking so each flop takes the pre-edge value of the one before it.
         r_sync1 <= req_raw;
         r_sync2 <= r_sync1;
      end
   end

   assign w_req_src = r_sync2;
`else
   assign w_req_src = req_raw;
`endif

   // Power-on init window: count cycles, drop init_active after the last one.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_init_cnt    <= '0;
         r_init_active <= 1'b1;
      end else if (r_init_active) begin
         r_init_cnt <= r_init_cnt + ICW'(1);
         if (r_init_cnt == INIT_LAST) begin
            r_init_active <= 1'b0;
         end
      end
   end

   // Requests are only sampled at the safe slot once init has finished.
   assign w_sample = (slot_cnt == SAFE_SLOT) && !r_init_active;

   // Request latch: holds between safe slots so grants never switch mid-transaction.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_req_lat <= '0;
      end else if (w_sample) begin
         r_req_lat <= w_req_src;
      end
   end

   // Decide the next grant from the latched requests (zero / one / many set).
   always_comb begin
      // NOTE: every output gets a default first so no path through this block infers a latch.
      w_any          = 1'b0;
      w_multi        = 1'b0;
      w_lowest       = '0;
      w_grant_nxt    = '0;
      w_rd_nxt       = 1'b0;
      w_conflict_nxt = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         w_multi     = w_multi | (w_any & r_req_lat[i]);
         w_lowest[i] = r_req_lat[i] & ~w_any;
         w_any       = w_any | r_req_lat[i];
      end
      if (r_init_active) begin
         w_grant_nxt[0] = 1'b1;
      end else if (!w_any) begin
         w_rd_nxt = 1'b1;
      end else if (!w_multi) begin
         w_grant_nxt = r_req_lat;
      end else begin
         w_conflict_nxt = 1'b1;
         if (PRIORITY == 0) begin
            w_rd_nxt = 1'b1;
         end else begin
            w_grant_nxt = w_lowest;
         end
      end
   end

   // Grant registers plus a one-cycle pulse whenever the selection changes.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_grant       <= '0;
         r_grant[0]    <= 1'b1;
         r_rd_grant    <= 1'b0;
         r_conflict    <= 1'b0;
         r_mode_change <= 1'b0;
      end else begin
         r_grant       <= w_grant_nxt;
         r_rd_grant    <= w_rd_nxt;
         r_conflict    <= w_conflict_nxt;
         r_mode_change <= ({w_rd_nxt, w_grant_nxt} != {r_rd_grant, r_grant});
      end
   end

   // AND-OR bus mux: the one-hot grant selects a channel, nothing selected yields 0.
   always_comb begin
      w_addr_mux = '0;
      w_data_mux = '0;
      for (int i = 0; i < N_REQ; i++) begin
         w_addr_mux = w_addr_mux | (ch_addr[i*AW +: AW] & {AW{r_grant[i]}});
         w_data_mux = w_data_mux | (ch_data[i*DW +: DW] & {DW{r_grant[i]}});
      end
   end

   assign grant       = r_grant;
   assign rd_grant    = r_rd_grant;
   assign init_active = r_init_active;
   assign conflict    = r_conflict;
   assign mode_change = r_mode_change;
   assign bus_addr    = r_rd_grant ? rd_addr : w_addr_mux;
   assign bus_data    = w_data_mux;
   assign bus_drive   = |r_grant;
   assign write_mode  = |r_grant;

endmodule

// File: tb/tb_rtc_mode_arbiter.sv
// Bench for rtc_mode_arbiter: two instances (exclusive and fixed-priority) share
// stimulus; a cycle-count based model predicts both, checked every falling edge.
module tb_rtc_mode_arbiter;

   localparam int         N_REQ = 4;
   localparam int         AW    = 8;
   localparam int         DW    = 8;
   localparam int         CW    = 7;
   localparam int         INIT  = 16;
   localparam logic [6:0] SAFE  = 7'h4A;

   logic                clk = 1'b0;
   logic                reset_n = 1'b0;
   logic [CW-1:0]       slot_cnt;
   logic [N_REQ-1:0]    req_raw;
   logic [N_REQ*AW-1:0] ch_addr;
   logic [N_REQ*DW-1:0] ch_data;
   logic [AW-1:0]       rd_addr;

   logic [N_REQ-1:0] grant_o [2];
   logic             rd_o    [2];
   logic             init_o  [2];
   logic [AW-1:0]    addr_o  [2];
   logic [DW-1:0]    data_o  [2];
   logic             drive_o [2];
   logic             wm_o    [2];
   logic             conf_o  [2];
   logic             mc_o    [2];

   for (genvar p = 0; p < 2; p++) begin : g_dut
      rtc_mode_arbiter #(
         .N_REQ(N_REQ), .AW(AW), .DW(DW), .CW(CW), .SAFE_SLOT(SAFE),
         .INIT_CYCLES(INIT), .PRIORITY(p)
      ) dut (
         .clk(clk), .reset_n(reset_n), .slot_cnt(slot_cnt), .req_raw(req_raw),
         .ch_addr(ch_addr), .ch_data(ch_data), .rd_addr(rd_addr),
         .grant(grant_o[p]), .rd_grant(rd_o[p]), .init_active(init_o[p]),
         .bus_addr(addr_o[p]), .bus_data(data_o[p]), .bus_drive(drive_o[p]),
         .write_mode(wm_o[p]), .conflict(conf_o[p]), .mode_change(mc_o[p])
      );
   end

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- behavioural model ----------------
   int               m_cyc;      // clock edges seen since reset released (saturates at INIT)
   logic [N_REQ-1:0] m_lat;
   logic [N_REQ-1:0] m_s1, m_s2;
   logic [N_REQ-1:0] m_grant [2];
   logic             m_rd    [2];
   logic             m_conf  [2];
   logic             m_mc    [2];

   function automatic void decide(input logic [N_REQ-1:0] lat, input int prio,
                                  output logic [N_REQ-1:0] g, output logic rd, output logic cf);
      int n = $countones(lat);
      int low = 0;
      for (int i = N_REQ - 1; i >= 0; i--) if (lat[i]) low = i;
      g  = '0;
      rd = 1'b0;
      cf = (n > 1);
      if (n == 0)         rd = 1'b1;
      else if (n == 1)    g = lat;
      else if (prio == 0) rd = 1'b1;
      else                g[low] = 1'b1;
   endfunction

   always @(posedge clk or negedge reset_n) begin : model
      logic [N_REQ-1:0] src;
      logic [N_REQ-1:0] g;
      logic             rd, cf, in_init;
      if (!reset_n) begin
         m_cyc = 0;
         m_lat = '0;
         m_s1  = '0;
         m_s2  = '0;
         for (int p = 0; p < 2; p++) begin
            m_grant[p] = 4'b0001;
            m_rd[p]    = 1'b0;
            m_conf[p]  = 1'b0;
            m_mc[p]    = 1'b0;
         end
      end else begin
         in_init = (m_cyc < INIT);
`ifdef REQ_SYNC_EN
         src  = m_s2;
         m_s2 = m_s1;
         m_s1 = req_raw;
`else
         src = req_raw;
`endif
         for (int p = 0; p < 2; p++) begin
            if (in_init) begin
               g = 4'b0001; rd = 1'b0; cf = 1'b0;
            end else begin
               decide(m_lat, p, g, rd, cf);
            end
            m_mc[p]    = (g != m_grant[p]) || (rd != m_rd[p]);
            m_grant[p] = g;
            m_rd[p]    = rd;
            m_conf[p]  = cf;
         end
         if (!in_init && slot_cnt == SAFE) m_lat = src;
         if (m_cyc < INIT) m_cyc++;
      end
   end

   function automatic logic [AW-1:0] exp_addr(input logic [N_REQ-1:0] g, input logic rd);
      logic [AW-1:0] a = '0;
      if (rd) return rd_addr;
      for (int i = 0; i < N_REQ; i++) if (g[i]) a = ch_addr[i*AW +: AW];
      return a;
   endfunction

   function automatic logic [DW-1:0] exp_data(input logic [N_REQ-1:0] g);
      logic [DW-1:0] d = '0;
      for (int i = 0; i < N_REQ; i++) if (g[i]) d = ch_data[i*DW +: DW];
      return d;
   endfunction

   // Compare both instances against the model on every falling edge.
   always @(negedge clk) begin
      for (int p = 0; p < 2; p++) begin
         check($sformatf("p%0d grant", p),       grant_o[p], m_grant[p]);
         check($sformatf("p%0d rd_grant", p),    rd_o[p],    m_rd[p]);
         check($sformatf("p%0d init_active", p), init_o[p],  m_cyc < INIT);
         check($sformatf("p%0d conflict", p),    conf_o[p],  m_conf[p]);
         check($sformatf("p%0d mode_change", p), mc_o[p],    m_mc[p]);
         check($sformatf("p%0d bus_addr", p),    addr_o[p],  exp_addr(m_grant[p], m_rd[p]));
         check($sformatf("p%0d bus_data", p),    data_o[p],  exp_data(m_grant[p]));
         check($sformatf("p%0d bus_drive", p),   drive_o[p], |m_grant[p]);
         check($sformatf("p%0d write_mode", p),  wm_o[p],    |m_grant[p]);
      end
   end

   // Hold a request for a few slots, pass one safe slot, then let the grant register.
   task automatic safe_cycle(input logic [N_REQ-1:0] r);
      req_raw  = r;
      slot_cnt = 7'h20;
      repeat (3) tick();
      slot_cnt = SAFE;
      tick();
      slot_cnt = 7'h21;
      tick();
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 1ms");
      $fatal(1, "timeout");
   end

   // ---------------- directed + random stimulus ----------------
   initial begin : stim
      int k;
      slot_cnt = SAFE;
      req_raw  = 4'b0010;
      ch_addr  = 32'hD4C3B2A1;
      ch_data  = 32'h48372615;
      rd_addr  = 8'h5C;
      #12;
      check("reset grant", grant_o[0], 4'b0001);
      check("reset init_active", init_o[0], 1'b1);
      check("reset rd_grant", rd_o[0], 1'b0);
      reset_n = 1'b1;

      // Init window: requests and safe slots ignored, last-init safe slot not sampled.
      repeat (15) tick();
      check("init still active at 15", init_o[0], 1'b1);
      check("init grant forced ch0", grant_o[0], 4'b0001);
      tick();
      check("init done at 16", init_o[0], 1'b0);
      check("grant ch0 until exit", grant_o[0], 4'b0001);
      slot_cnt = 7'h20;
      req_raw  = 4'b0000;
      tick();
      check("exit rd_grant", rd_o[0], 1'b1);
      check("exit grant", grant_o[0], 4'b0000);
      check("exit bus_addr", addr_o[0], 8'h5C);
      check("exit mode_change", mc_o[0], 1'b1);
      tick();
      check("exit mode_change single", mc_o[0], 1'b0);

      // Single request: nothing until the safe slot, then one cycle later.
      req_raw = 4'b0100;
      repeat (3) tick();
      check("no grant before safe slot", rd_o[0], 1'b1);
      slot_cnt = SAFE;
      tick();
      slot_cnt = 7'h21;
      check("grant latency 1 cycle", grant_o[0], 4'b0000);
      tick();
      check("ch2 grant", grant_o[0], 4'b0100);
      check("ch2 bus_addr", addr_o[0], 8'hC3);
      check("ch2 bus_drive", drive_o[0], 1'b1);
      check("ch2 write_mode", wm_o[0], 1'b1);

      // Two requests: exclusive falls back to read, fixed priority picks channel 1.
      safe_cycle(4'b0110);
      check("excl conflict", conf_o[0], 1'b1);
      check("excl rd_grant", rd_o[0], 1'b1);
      check("excl bus_drive", drive_o[0], 1'b0);
      check("excl bus_data", data_o[0], 8'h00);
      check("prio grant", grant_o[1], 4'b0010);
      check("prio conflict", conf_o[1], 1'b1);

      // Dropped request keeps its grant until the next safe slot.
      safe_cycle(4'b0010);
      check("ch1 grant", grant_o[0], 4'b0010);
      req_raw  = 4'b0000;
      slot_cnt = 7'h10;
      repeat (5) tick();
      check("ch1 held after drop", grant_o[0], 4'b0010);
      slot_cnt = SAFE;
      tick();
      slot_cnt = 7'h21;
      tick();
      check("drop rd_grant", rd_o[0], 1'b1);
      check("drop mode_change", mc_o[0], 1'b1);
      tick();
      check("drop mode_change single", mc_o[0], 1'b0);

      // Asynchronous reset mid-operation, then a full init re-run.
      safe_cycle(4'b1000);
      check("ch3 grant", grant_o[0], 4'b1000);
      #3 reset_n = 1'b0;
      #1;
      check("async reset grant", grant_o[0], 4'b0001);
      check("async reset init_active", init_o[0], 1'b1);
      check("async reset rd_grant", rd_o[0], 1'b0);
      req_raw  = 4'b0000;
      slot_cnt = 7'h20;
      @(negedge clk);
      reset_n = 1'b1;
      k = 0;
      while (init_o[0] && k < 100) begin
         tick();
         k++;
      end
      check("init re-run length", k, INIT);
      repeat (2) tick();

`ifdef REQ_SYNC_EN
      // A request rising one cycle before the safe slot is only seen at the next one.
      req_raw  = 4'b0100;
      slot_cnt = 7'h20;
      tick();
      slot_cnt = SAFE;
      tick();
      slot_cnt = 7'h21;
      tick();
      check("sync missed grant", grant_o[0], 4'b0000);
      check("sync missed rd_grant", rd_o[0], 1'b1);
      slot_cnt = SAFE;
      tick();
      slot_cnt = 7'h21;
      tick();
      check("sync captured grant", grant_o[0], 4'b0100);
`endif

      // Randomised phase: checked by the model on every cycle.
      for (int c = 0; c < 4000; c++) begin
         slot_cnt = ($urandom_range(0, 3) == 0) ? SAFE : CW'($urandom);
         if ($urandom_range(0, 7) == 0) req_raw = N_REQ'($urandom);
         ch_addr = $urandom;
         ch_data = $urandom;
         rd_addr = AW'($urandom);
         if ($urandom_range(0, 499) == 0) begin
            #1 reset_n = 1'b0;
            #1 reset_n = 1'b1;
         end
         tick();
      end

      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/rtc_mode_arbiter.md
Name: rtc_mode_arbiter

Overview:
Parametrised successor to the RTC top-level mode multiplexing. It generalises the fixed init/reset/write/program/timer-run selection to N_REQ request channels with a selectable priority mode. Operator requests are sampled only at the safe bus slot, the power-on init window is enforced, and one address/data source is granted onto the RTC protocol engine. It also drives the write/read indicator and a bus-drive enable that replaces tri-state muxing.

Parameters:
N_REQ, 4, number of write-type request channels; channel 0 is the init/reload channel
AW, 8, address width per channel
DW, 8, data width per channel
CW, 7, width of the bus slot counter
SAFE_SLOT, 7'h4A, slot value at which requests may be sampled
INIT_CYCLES, 1035, length of the power-on init window in clk cycles (must be at least 1)
PRIORITY, 0, 0 = exclusive (multiple requests give conflict and read mode), 1 = fixed priority (lowest index wins)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
slot_cnt  in  CW  transaction position from the function generator
req_raw  in  N_REQ  operator mode requests (switches), active-high
ch_addr  in  N_REQ*AW  flattened per-channel addresses; channel i is at [i*AW +: AW]
ch_data  in  N_REQ*DW  flattened per-channel write data
rd_addr  in  AW  read-sequencer address
grant  out  N_REQ  one-hot write grant
rd_grant  out  1  read mode active
init_active  out  1  power-on init window in progress
bus_addr  out  AW  selected address
bus_data  out  DW  selected write data; 0 when bus_drive=0
bus_drive  out  1  write data valid/drive enable
write_mode  out  1  1 = write transaction, 0 = read (inverse of IndicadorMaquina semantics)
conflict  out  1  more than one request latched at the last sample
mode_change  out  1  one-cycle pulse when {rd_grant, grant} changes

Behaviour:
- Reset (async assert, sync-released usage): init_active=1, init counter=0, req_lat=0, grant=1 (channel 0 only), rd_grant=0, conflict=0, mode_change=0.
- Init window: the counter increments every cycle while init_active=1.
  - When the counter reaches INIT_CYCLES-1, init_active clears on the next edge.
  - grant stays forced to channel 0 throughout, and req_raw is ignored.
- Init exit: the cycle after init_active falls, grant=0 and rd_grant=1, with mode_change pulsed once.
- Sampling: req_lat <= req_src only on cycles where slot_cnt==SAFE_SLOT and init_active==0; otherwise req_lat holds.
  - A safe slot that coincides with the last init cycle is not sampled.
- Grant is registered one cycle after req_lat updates, so the latency from the sampling edge to grant is 1 cycle:
  - popcount(req_lat)==0: rd_grant=1, grant=0, conflict=0.
  - popcount==1: grant=req_lat, rd_grant=0, conflict=0.
  - popcount>1 with PRIORITY=0: grant=0, rd_grant=1, conflict=1.
  - popcount>1 with PRIORITY=1: grant=lowest set bit, rd_grant=0, conflict=1.
- Output mux (combinational from the grant registers):
  - bus_addr = granted ch_addr, or rd_addr when rd_grant=1.
  - bus_data = granted ch_data, or 0 when rd_grant=1.
  - bus_drive = |grant.
  - write_mode = |grant.
- mode_change: registered compare of {rd_grant, grant} against its previous value; high for exactly one cycle per change.
- A request dropped between safe slots keeps its grant until the next safe slot; there is no mid-transaction switching.
- reset_n asserted mid-operation aborts immediately to reset values, and init restarts from count 0.
- Width rules: the init counter is $clog2(INIT_CYCLES+1) bits; no other arithmetic.

Optional Feature:
REQ_SYNC_EN
- Defined: req_raw passes through a 2-flop synchronizer (reset to 0) to form req_src. Sampling sees levels delayed by 2 cycles.
- Undefined: req_src = req_raw directly.

Test Plan:
- Reset, INIT_CYCLES=16:
  - grant=4'b0001 and init_active=1 for 16 cycles.
  - Then rd_grant=1 and bus_addr=rd_addr, with one mode_change pulse.
  - req_raw=4'b0010 during init is ignored.
- After init, req_raw=4'b0100 asserted at slot 7'h20:
  - No change until slot_cnt=7'h4A.
  - 1 cycle later: grant=4'b0100, bus_addr=ch_addr[2], bus_drive=1, write_mode=1.
- PRIORITY=0, req_raw=4'b0110 at the safe slot:
  - conflict=1, rd_grant=1, bus_drive=0, bus_data=0.
- PRIORITY=1, same stimulus:
  - grant=4'b0010, conflict=1.
- Channel 1 granted, req_raw dropped at slot 7'h10:
  - grant held until the next 7'h4A; then rd_grant=1 with a single mode_change pulse.
- reset_n pulsed low while grant=4'b1000:
  - Outputs return to reset values asynchronously, and the init window is re-run in full.
- With REQ_SYNC_EN defined:
  - A request rising 1 cycle before the safe slot is missed at that slot and captured at the next one.
